// File: rtl/vedic_8x8_seq_ctrl.sv
// Purpose: 8x8 unsigned multiply sequenced over one shared 4x4 Vedic core, four nibble steps.
// Latency: 4 enabled clocks from operand accept to out_valid (1 clock with zero bypass).
// Backpressure: result held in DONE until out_ready; in_ready low whenever not IDLE or ena=0.
module vedic_8x8_seq_ctrl #(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        busy,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  step;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] acc;
  logic [15:0] p_q;
  logic [15:0] pp_shifted;
  logic [15:0] acc_sum;
  logic        accept;
  logic        zero_op;

  assign accept  = in_valid & in_ready;
  assign zero_op = ZERO_BYPASS && ((in_a == 8'd0) || (in_b == 8'd0));
  assign acc_sum = acc + pp_shifted;
  assign out_p   = p_q;

  // Position the 8-bit partial product by the weight of the nibble pair in this step.
  always_comb begin
    pp_shifted = {8'd0, mul_p};
    case (step)
      2'd0:    pp_shifted = {8'd0, mul_p};
      2'd1,
      2'd2:    pp_shifted = {4'd0, mul_p, 4'd0};
      default: pp_shifted = {mul_p, 8'd0};
    endcase
  end

  // State register; ena=0 freezes the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  // Next-state: accept only from IDLE, walk four MUL steps, wait in DONE for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = zero_op ? S_DONE : S_MUL;
      end
      S_MUL: begin
        if (step == 2'd3) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: handshakes and nibble selection decoded from state and step.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    mul_a     = 4'd0;
    mul_b     = 4'd0;
    case (state)
      S_IDLE: begin
        // rst_n term keeps the handshake closed while reset is asserted.
        in_ready = ena & rst_n;
      end
      S_MUL: begin
        busy  = 1'b1;
        mul_a = step[1] ? a_q[7:4] : a_q[3:0];
        mul_b = step[0] ? b_q[7:4] : b_q[3:0];
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand capture, shift-accumulate, and the held result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= 8'd0;
      b_q  <= 8'd0;
      acc  <= 16'd0;
      step <= 2'd0;
      p_q  <= 16'd0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q  <= in_a;
            b_q  <= in_b;
            acc  <= 16'd0;
            step <= 2'd0;
            if (zero_op) p_q <= 16'd0;
          end
        end
        S_MUL: begin
          acc  <= acc_sum;
          // Wraps back to 0 after the last step.
          step <= step + 2'd1;
          // Result register loads only on completion so no partial sum is ever shown.
          if (step == 2'd3) p_q <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule
